// File: rtl/fb_fill_master_if.sv
// Wishbone classic master/slave bundle for fb_fill_master.
// Signals:
//   wb_cyc, wb_stb, wb_we  cycle, strobe and write-enable (master -> slave)
//   wb_adr, wb_data_o      byte address and write data     (master -> slave)
//   wb_ack, wb_err         cycle termination               (slave -> master)
//   wb_data_i              read data, registered by target (slave -> master)
interface fb_fill_master_if;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [31:0] wb_adr;
  logic [31:0] wb_data_o;
  logic        wb_ack;
  logic        wb_err;
  logic [31:0] wb_data_i;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_data_o,
    input  wb_ack, wb_err, wb_data_i
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_data_o,
    output wb_ack, wb_err, wb_data_i
  );
endinterface

// File: rtl/fb_fill_master.sv
// fb_fill_master: fills a rectangle of 4-pixel column groups in a framebuffer
// by driving its register window over Wishbone (single classic cycles).
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                request pulse, accepted only when idle
//   col_q, row           first column group / first row (both wrap)
//   width_q, height      rectangle size; zero in either finishes at once
//   color, flip          fill value and buffer flip request, latched on start
//   busy, done, error    status: busy outside IDLE, one-cycle done, sticky error
//   wb                   Wishbone master port (fb_fill_master_if.master)
// Optional feature: define FB_FILL_POLL_TIMEOUT_EN to bound every status
// poll loop to POLL_LIMIT reads; without it the poll loops wait forever.
//
// state  | meaning
// IDLE   | waiting for start
// GETBUF | read status once, target buffer = inverse of current buffer
// PIX    | write color to the four pixel word registers
// PTR    | write pointer (target buffer, row, column group)
// CSET   | write command WRITE_PIXELS
// POLL   | read status until WRITE_ACK
// CCLR   | write command clear
// NEXT   | advance column group, then row
// FSET   | write command FLIP_BUFFERS
// FPOLL  | read status until CURRENT_BUFFER equals target buffer
// FCLR   | write command clear
// DONE   | pulse done
module fb_fill_master #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned POLL_LIMIT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [8:0]       col_q,
  input  logic [10:0]      row,
  input  logic [9:0]       width_q,
  input  logic [11:0]      height,
  input  logic [31:0]      color,
  input  logic             flip,
  output logic             busy,
  output logic             done,
  output logic             error,
  fb_fill_master_if.master wb
);

  typedef enum logic [3:0] {
    S_IDLE, S_GETBUF, S_PIX, S_PTR, S_CSET, S_POLL,
    S_CCLR, S_NEXT, S_FSET, S_FPOLL, S_FCLR, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        gap_q;
  logic [1:0]  pix_q;
  logic [8:0]  x_q;
  logic [10:0] y_q;
  logic [8:0]  col_lq;
  logic [10:0] row_lq;
  logic [9:0]  width_lq;
  logic [11:0] height_lq;
  logic [31:0] color_lq;
  logic        flip_lq;
  logic        tb_q;

  logic        bus_act, bus_we;
  logic [4:0]  bus_off;
  logic [31:0] bus_wdata;
  logic        acc_ok, acc_err, start_ok, last_px, poll_expired, set_err;
  logic [10:0] r_cur;
  logic [8:0]  c_cur;

  // Natural truncation gives the mod-2048 row and mod-512 column wrap.
  assign r_cur    = row_lq + y_q;
  assign c_cur    = col_lq + x_q;
  assign last_px  = ({1'b0, x_q} == width_lq - 10'd1) &&
                    ({1'b0, y_q} == height_lq - 12'd1);
  assign start_ok = (state_q == S_IDLE) && start;
  // err wins over ack when both are high.
  assign acc_ok   = bus_act && !gap_q && wb.wb_ack && !wb.wb_err;
  assign acc_err  = bus_act && !gap_q && wb.wb_err;

`ifdef FB_FILL_POLL_TIMEOUT_EN
  localparam int PW = $clog2(POLL_LIMIT + 1);
  logic [PW-1:0] poll_left_q;

  assign poll_expired = (poll_left_q == PW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      poll_left_q <= '0;
    end else if ((state_d == S_POLL && state_q != S_POLL) ||
                 (state_d == S_FPOLL && state_q != S_FPOLL)) begin
      poll_left_q <= PW'(POLL_LIMIT);
    end else if ((state_q == S_POLL || state_q == S_FPOLL) && gap_q) begin
      poll_left_q <= poll_left_q - PW'(1);
    end
  end
`else
  assign poll_expired = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    bus_act   = 1'b0;
    bus_we    = 1'b0;
    bus_off   = 5'h00;
    bus_wdata = 32'h0;
    set_err   = 1'b0;

    case (state_q)
      S_GETBUF, S_POLL, S_FPOLL: begin
        bus_act = 1'b1;
        bus_off = 5'h18;
      end
      S_PIX: begin
        bus_act   = 1'b1;
        bus_we    = 1'b1;
        bus_off   = {1'b0, pix_q, 2'b00};
        bus_wdata = color_lq;
      end
      S_PTR: begin
        bus_act   = 1'b1;
        bus_we    = 1'b1;
        bus_off   = 5'h10;
        bus_wdata = {7'b0, tb_q, r_cur, c_cur, 4'b0};
      end
      S_CSET: begin
        bus_act   = 1'b1;
        bus_we    = 1'b1;
        bus_off   = 5'h14;
        bus_wdata = 32'h1;
      end
      S_FSET: begin
        bus_act   = 1'b1;
        bus_we    = 1'b1;
        bus_off   = 5'h14;
        bus_wdata = 32'h10;
      end
      S_CCLR, S_FCLR: begin
        bus_act = 1'b1;
        bus_we  = 1'b1;
        bus_off = 5'h14;
      end
      default: ;
    endcase

    case (state_q)
      S_IDLE: begin
        if (start) state_d = (width_q == 10'd0 || height == 12'd0) ? S_DONE : S_GETBUF;
      end
      S_NEXT: begin
        if (last_px) state_d = flip_lq ? S_FSET : S_DONE;
        else         state_d = S_PIX;
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        if (acc_err) begin
          set_err = 1'b1;
          state_d = S_DONE;
        end else if (gap_q) begin
          // Gap cycle: registered read data is valid on wb_data_i now.
          case (state_q)
            S_GETBUF: state_d = S_PIX;
            S_PIX:    state_d = (pix_q == 2'd3) ? S_PTR : S_PIX;
            S_PTR:    state_d = S_CSET;
            S_CSET:   state_d = S_POLL;
            S_POLL: begin
              if (wb.wb_data_i[0]) begin
                state_d = S_CCLR;
              end else if (poll_expired) begin
                set_err = 1'b1;
                state_d = S_DONE;
              end
            end
            S_CCLR:   state_d = S_NEXT;
            S_FSET:   state_d = S_FPOLL;
            S_FPOLL: begin
              if (wb.wb_data_i[12] == tb_q) begin
                state_d = S_FCLR;
              end else if (poll_expired) begin
                set_err = 1'b1;
                state_d = S_DONE;
              end
            end
            S_FCLR:   state_d = S_DONE;
            default:  ;
          endcase
        end
      end
    endcase
  end

  assign wb.wb_cyc    = bus_act && !gap_q;
  assign wb.wb_stb    = bus_act && !gap_q;
  assign wb.wb_we     = bus_act && !gap_q && bus_we;
  assign wb.wb_adr    = (bus_act && !gap_q) ? (BASE_ADDR | {27'b0, bus_off}) : 32'h0;
  assign wb.wb_data_o = (bus_act && !gap_q && bus_we) ? bus_wdata : 32'h0;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q     <= 1'b0;
      pix_q     <= 2'd0;
      x_q       <= 9'd0;
      y_q       <= 11'd0;
      col_lq    <= 9'd0;
      row_lq    <= 11'd0;
      width_lq  <= 10'd0;
      height_lq <= 12'd0;
      color_lq  <= 32'h0;
      flip_lq   <= 1'b0;
      tb_q      <= 1'b0;
      error     <= 1'b0;
    end else begin
      gap_q <= acc_ok;
      if (set_err) error <= 1'b1;
      if (start_ok) begin
        col_lq    <= col_q;
        row_lq    <= row;
        width_lq  <= width_q;
        height_lq <= height;
        color_lq  <= color;
        flip_lq   <= flip;
        x_q       <= 9'd0;
        y_q       <= 11'd0;
        pix_q     <= 2'd0;
        error     <= 1'b0;
      end
      if (state_q == S_GETBUF && gap_q) tb_q <= ~wb.wb_data_i[12];
      if (state_q == S_PIX && gap_q) pix_q <= pix_q + 2'd1;
      if (state_q == S_NEXT && !last_px) begin
        if ({1'b0, x_q} == width_lq - 10'd1) begin
          x_q <= 9'd0;
          y_q <= y_q + 11'd1;
        end else begin
          x_q <= x_q + 9'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fb_fill_master.sv
// Self-checking bench for fb_fill_master: a behavioural Wishbone target with
// a status register model, a protocol monitor, and a transaction-list model
// of the expected register accesses built from the fill rules.
module tb_fb_fill_master;
  localparam logic [31:0] BASE = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  col_q = '0;
  logic [10:0] row = '0;
  logic [9:0]  width_q = '0;
  logic [11:0] height = '0;
  logic [31:0] color = '0;
  logic        flip = 1'b0;
  logic        busy, done, error;

  always #5 clk = ~clk;

  fb_fill_master_if wb();

  fb_fill_master #(.BASE_ADDR(BASE), .POLL_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .col_q(col_q), .row(row),
    .width_q(width_q), .height(height), .color(color), .flip(flip),
    .busy(busy), .done(done), .error(error), .wb(wb)
  );

  int n_checks = 0;
  int n_pass = 0;

  // Target configuration set by the tests
  int   ack_reads = 1;
  int   flip_reads = 1;
  int   err_at = -1;
  logic init_buf = 1'b0;
  logic slave_clr = 1'b0;

  // Each entry: {we, adr, write data (0 for reads)}
  logic [64:0] log_q[$];
  logic [64:0] exp_q[$];

  // Behavioural target
  logic        cur_buf = 1'b0;
  logic [31:0] cmd_reg = '0;
  int          reads_since = 0;
  int          wait_cnt = 0;
  logic        rd_pend;
  logic [31:0] rd_val;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb.wb_ack    <= 1'b0;
      wb.wb_err    <= 1'b0;
      wb.wb_data_i <= 32'h0;
      rd_pend      <= 1'b0;
      rd_val       <= 32'h0;
      wait_cnt     = 0;
      cmd_reg      = 32'h0;
      reads_since  = 0;
    end else begin
      wb.wb_ack    <= 1'b0;
      wb.wb_err    <= 1'b0;
      wb.wb_data_i <= rd_pend ? rd_val : $urandom;
      rd_pend      <= 1'b0;
      if (slave_clr) begin
        log_q.delete();
        cur_buf     = init_buf;
        cmd_reg     = 32'h0;
        reads_since = 0;
      end else if (wb.wb_cyc && wb.wb_stb && !wb.wb_ack && !wb.wb_err) begin
        if (wait_cnt > 0) begin
          wait_cnt = wait_cnt - 1;
        end else begin
          wait_cnt = $urandom_range(0, 2);
          if (int'(log_q.size()) == err_at) begin
            wb.wb_err <= 1'b1;
            wb.wb_ack <= 1'b1;
          end else begin
            wb.wb_ack <= 1'b1;
            if (wb.wb_we && wb.wb_adr == BASE + 32'h14) begin
              cmd_reg     = wb.wb_data_o;
              reads_since = 0;
            end else if (!wb.wb_we && wb.wb_adr == BASE + 32'h18) begin
              reads_since = reads_since + 1;
              if (cmd_reg[4] && reads_since == flip_reads) cur_buf = ~cur_buf;
              rd_val  <= ($urandom & ~32'h0000_1001) | (cur_buf ? 32'h1000 : 32'h0) |
                         ((cmd_reg[0] && reads_since >= ack_reads) ? 32'h1 : 32'h0);
              rd_pend <= 1'b1;
            end
          end
          log_q.push_back({wb.wb_we, wb.wb_adr, wb.wb_we ? wb.wb_data_o : 32'h0});
        end
      end
    end
  end

  // Protocol monitor: one idle cycle after every termination, stable request
  int          done_cnt = 0;
  int          proto_err = 0;
  int          cyc_cnt = 0;
  logic        prev_end = 1'b0;
  logic        prev_cyc = 1'b0;
  logic [64:0] prev_sig = '0;

  always @(negedge clk) begin
    if (slave_clr) begin
      done_cnt  = 0;
      proto_err = 0;
      cyc_cnt   = 0;
    end else begin
      if (done) done_cnt = done_cnt + 1;
      if (wb.wb_cyc) cyc_cnt = cyc_cnt + 1;
      if (prev_end && wb.wb_cyc) proto_err = proto_err + 1;
      if (prev_cyc && !prev_end && wb.wb_cyc &&
          {wb.wb_we, wb.wb_adr, wb.wb_data_o} != prev_sig) proto_err = proto_err + 1;
    end
    prev_end = wb.wb_cyc && (wb.wb_ack || wb.wb_err);
    prev_cyc = wb.wb_cyc;
    prev_sig = {wb.wb_we, wb.wb_adr, wb.wb_data_o};
  end

  // Expected access list from the fill rules
  function automatic void model_fill(input int c, input int r, input int w, input int h,
                                     input logic [31:0] colr, input bit fl, input bit tb,
                                     input int ar, input int fr);
    logic [31:0] p;
    exp_q.delete();
    exp_q.push_back({1'b0, BASE + 32'h18, 32'h0});
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        for (int k = 0; k < 4; k++) exp_q.push_back({1'b1, BASE + 32'(4 * k), colr});
        p = 32'((int'(tb) << 24) + (((r + y) % 2048) << 13) + (((c + x) % 512) << 4));
        exp_q.push_back({1'b1, BASE + 32'h10, p});
        exp_q.push_back({1'b1, BASE + 32'h14, 32'h1});
        for (int k = 0; k < ar; k++) exp_q.push_back({1'b0, BASE + 32'h18, 32'h0});
        exp_q.push_back({1'b1, BASE + 32'h14, 32'h0});
      end
    end
    if (fl) begin
      exp_q.push_back({1'b1, BASE + 32'h14, 32'h10});
      for (int k = 0; k < fr; k++) exp_q.push_back({1'b0, BASE + 32'h18, 32'h0});
      exp_q.push_back({1'b1, BASE + 32'h14, 32'h0});
    end
  endfunction

  task automatic slave_setup(input logic ib, input int ar, input int fr, input int ea);
    init_buf   = ib;
    ack_reads  = ar;
    flip_reads = fr;
    err_at     = ea;
    @(posedge clk); #1;
    slave_clr = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    slave_clr = 1'b0;
  endtask

  // Starts a fill; with poke, scrambles the inputs and re-pulses start mid-run.
  task automatic run_fill(input logic [8:0] c, input logic [10:0] r, input logic [9:0] w,
                          input logic [11:0] h, input logic [31:0] colr, input logic fl,
                          input bit poke, output bit tmo);
    @(posedge clk); #1;
    col_q = c; row = r; width_q = w; height = h; color = colr; flip = fl;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tmo = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (done) begin
        tmo = 1'b0;
        break;
      end
      if (poke && i == 1) begin
        col_q = ~c; row = ~r; color = ~colr; flip = ~fl; width_q = 10'd7;
      end
      start = (poke && i == 12);
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({wb.wb_cyc, wb.wb_stb, wb.wb_we, wb.wb_adr, wb.wb_data_o, busy, done, error} !== '0)
      $display("FAIL reset_outputs got cyc=%b adr=%h dat=%h busy=%b done=%b err=%b exp all 0",
               wb.wb_cyc, wb.wb_adr, wb.wb_data_o, busy, done, error);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    bit tmo;
    slave_setup(1'b0, 1, 1, -1);
    run_fill(9'd3, 11'd5, 10'd1, 12'd1, 32'hAABB_CCDD, 1'b0, 1'b0, tmo);
    model_fill(3, 5, 1, 1, 32'hAABB_CCDD, 1'b0, 1'b1, 1, 1);
    n_checks++;
    if (tmo || done_cnt != 1) $display("FAIL basic_done got tmo=%0d pulses=%0d exp 0/1", tmo, done_cnt);
    else n_pass++;
    n_checks++;
    if (log_q.size() != exp_q.size()) $display("FAIL basic_len got %0d exp %0d", log_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      n_checks++;
      if (log_q[i] !== exp_q[i]) $display("FAIL basic_txn%0d got %h exp %h", i, log_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (log_q.size() < 6 || log_q[5][31:0] !== 32'h0100_A030)
      $display("FAIL basic_ptr got %h exp 0100a030", log_q.size() < 6 ? 32'hx : log_q[5][31:0]);
    else n_pass++;
    n_checks++;
    if (proto_err != 0 || busy !== 1'b0 || error !== 1'b0)
      $display("FAIL basic_proto got proto=%0d busy=%b err=%b exp 0/0/0", proto_err, busy, error);
    else n_pass++;
  endtask

  task automatic test_wrap();
    bit tmo;
    slave_setup(1'b1, 1, 1, -1);
    run_fill(9'd511, 11'd100, 10'd2, 12'd1, 32'h1234_5678, 1'b0, 1'b0, tmo);
    model_fill(511, 100, 2, 1, 32'h1234_5678, 1'b0, 1'b0, 1, 1);
    n_checks++;
    if (tmo || log_q.size() != exp_q.size())
      $display("FAIL wrap_len got %0d tmo=%0d exp %0d", log_q.size(), tmo, exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      n_checks++;
      if (log_q[i] !== exp_q[i]) $display("FAIL wrap_txn%0d got %h exp %h", i, log_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (log_q.size() < 14 || log_q[5][12:4] !== 9'd511 || log_q[13][12:4] !== 9'd0 ||
        log_q[13][23:13] !== 11'd100)
      $display("FAIL wrap_cols got size=%0d exp cols 511,0 row 100", log_q.size());
    else n_pass++;
  endtask

  task automatic test_flip();
    bit tmo;
    slave_setup(1'b1, 2, 3, -1);
    run_fill(9'd10, 11'd20, 10'd1, 12'd1, 32'hCAFE_F00D, 1'b1, 1'b1, tmo);
    model_fill(10, 20, 1, 1, 32'hCAFE_F00D, 1'b1, 1'b0, 2, 3);
    n_checks++;
    if (tmo || done_cnt != 1 || error !== 1'b0)
      $display("FAIL flip_done got tmo=%0d pulses=%0d err=%b exp 0/1/0", tmo, done_cnt, error);
    else n_pass++;
    n_checks++;
    if (log_q.size() != exp_q.size()) $display("FAIL flip_len got %0d exp %0d", log_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      n_checks++;
      if (log_q[i] !== exp_q[i]) $display("FAIL flip_txn%0d got %h exp %h", i, log_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (log_q.size() < 6 || log_q[5][24] !== 1'b0)
      $display("FAIL flip_tb got size=%0d bit24=%b exp 0", log_q.size(), log_q.size() < 6 ? 1'bx : log_q[5][24]);
    else n_pass++;
  endtask

  task automatic test_err();
    bit tmo;
    slave_setup(1'b0, 1, 1, 2);
    run_fill(9'd0, 11'd0, 10'd2, 12'd2, 32'h5555_AAAA, 1'b1, 1'b0, tmo);
    model_fill(0, 0, 2, 2, 32'h5555_AAAA, 1'b1, 1'b1, 1, 1);
    err_at = -1;
    n_checks++;
    if (tmo || error !== 1'b1 || done_cnt != 1 || busy !== 1'b0)
      $display("FAIL err_state got tmo=%0d err=%b pulses=%0d busy=%b exp 0/1/1/0", tmo, error, done_cnt, busy);
    else n_pass++;
    n_checks++;
    if (log_q.size() != 3) $display("FAIL err_len got %0d exp 3", log_q.size());
    else n_pass++;
    for (int i = 0; i < 3 && i < log_q.size(); i++) begin
      n_checks++;
      if (log_q[i] !== exp_q[i]) $display("FAIL err_txn%0d got %h exp %h", i, log_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_empty();
    slave_setup(1'b0, 1, 1, -1);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      width_q = (k == 0) ? 10'd5 : 10'd0;
      height  = (k == 0) ? 12'd0 : 12'd3;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n_checks++;
      if (done !== 1'b1 || error !== 1'b0)
        $display("FAIL empty%0d_done got done=%b err=%b exp 1/0", k, done, error);
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0)
        $display("FAIL empty%0d_idle got done=%b busy=%b exp 0/0", k, done, busy);
      else n_pass++;
    end
    n_checks++;
    if (cyc_cnt != 0 || log_q.size() != 0)
      $display("FAIL empty_nobus got cyc_cycles=%0d txns=%0d exp 0/0", cyc_cnt, log_q.size());
    else n_pass++;
  endtask

  task automatic test_random();
    bit tmo;
    logic [8:0]  c;
    logic [10:0] r;
    logic [9:0]  w;
    logic [11:0] h;
    logic [31:0] colr;
    logic        fl, ib;
    int          ar, fr;
    for (int it = 0; it < 8; it++) begin
      c    = ($urandom_range(0, 1) == 1) ? 9'(510 + $urandom_range(0, 1)) : 9'($urandom);
      r    = ($urandom_range(0, 1) == 1) ? 11'd2047 : 11'($urandom);
      w    = 10'($urandom_range(1, 3));
      h    = 12'($urandom_range(1, 2));
      colr = $urandom;
      fl   = 1'($urandom_range(0, 1));
      ib   = 1'($urandom_range(0, 1));
      ar   = $urandom_range(1, 3);
      fr   = $urandom_range(1, 3);
      slave_setup(ib, ar, fr, -1);
      run_fill(c, r, w, h, colr, fl, 1'b0, tmo);
      model_fill(int'(c), int'(r), int'(w), int'(h), colr, fl, ~ib, ar, fr);
      n_checks++;
      if (tmo || done_cnt != 1 || error !== 1'b0 || proto_err != 0)
        $display("FAIL rand%0d_status got tmo=%0d pulses=%0d err=%b proto=%0d exp 0/1/0/0",
                 it, tmo, done_cnt, error, proto_err);
      else n_pass++;
      n_checks++;
      if (log_q.size() != exp_q.size())
        $display("FAIL rand%0d_len got %0d exp %0d", it, log_q.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
        n_checks++;
        if (log_q[i] !== exp_q[i]) $display("FAIL rand%0d_txn%0d got %h exp %h", it, i, log_q[i], exp_q[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_poll();
    bit hit;
    slave_setup(1'b0, 1000, 1, -1);
    @(posedge clk); #1;
    col_q = 9'd1; row = 11'd1; width_q = 10'd1; height = 12'd1; flip = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (wb.wb_cyc && !wb.wb_we && wb.wb_adr == BASE + 32'h18 && log_q.size() >= 7) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (!hit) $display("FAIL rstpoll_reach got no poll read exp poll read");
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({wb.wb_cyc, wb.wb_stb, wb.wb_we, wb.wb_adr, wb.wb_data_o, busy, done, error} !== '0)
      $display("FAIL rstpoll_outputs got cyc=%b busy=%b adr=%h exp all 0", wb.wb_cyc, busy, wb.wb_adr);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || wb.wb_cyc !== 1'b0)
      $display("FAIL rstpoll_after got busy=%b cyc=%b exp 0/0", busy, wb.wb_cyc);
    else n_pass++;
  endtask

`ifdef FB_FILL_POLL_TIMEOUT_EN
  task automatic test_timeout();
    bit tmo;
    slave_setup(1'b0, 1000, 1, -1);
    run_fill(9'd7, 11'd9, 10'd1, 12'd1, 32'h0F0F_0F0F, 1'b0, 1'b0, tmo);
    model_fill(7, 9, 1, 1, 32'h0F0F_0F0F, 1'b0, 1'b1, 4, 1);
    void'(exp_q.pop_back());
    n_checks++;
    if (tmo || error !== 1'b1 || done_cnt != 1)
      $display("FAIL timeout_state got tmo=%0d err=%b pulses=%0d exp 0/1/1", tmo, error, done_cnt);
    else n_pass++;
    n_checks++;
    if (log_q.size() != exp_q.size()) $display("FAIL timeout_len got %0d exp %0d", log_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      n_checks++;
      if (log_q[i] !== exp_q[i]) $display("FAIL timeout_txn%0d got %h exp %h", i, log_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_flip();
    test_err();
    test_empty();
    test_random();
    test_reset_poll();
`ifdef FB_FILL_POLL_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fb_fill_master.md
FB_FILL_MASTER -- requirements
Module: fb_fill_master

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the framebuffer register window base (32-byte aligned).
REQ-002 SHALL have parameter POLL_LIMIT, default 1024, meaning the maximum status polls per wait (used only under REQ-030).
REQ-003 SHALL have port clk  in  1  meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n  in  1  meaning the reset, which is asynchronous and active-low.
REQ-005 SHALL have ports start in 1 (request pulse), col_q in 9 (first 4-pixel column group), row in 11 (first row), width_q in 10 (column groups, 0..512) and height in 12 (rows, 0..2048).
REQ-006 SHALL have ports color in 32 (fill pixel value) and flip in 1 (flip buffers after the fill), both sampled with start.
REQ-007 SHALL have outputs busy 1, done 1 (one-cycle pulse) and error 1 (sticky).
REQ-008 SHALL have Wishbone master outputs wb_cyc 1, wb_stb 1, wb_we 1, wb_adr 32 and wb_data_o 32.
REQ-009 SHALL have Wishbone master inputs wb_ack 1, wb_err 1 and wb_data_i 32.

Function
REQ-010 SHALL use these register offsets from BASE_ADDR: pixel words 0x00-0x0C, pointer 0x10, command 0x14, status 0x18 (read-only).
REQ-011 SHALL use command bit 0 = WRITE_PIXELS and bit 4 = FLIP_BUFFERS.
REQ-012 SHALL use status bit 0 = WRITE_ACK and bit 12 = CURRENT_BUFFER.
REQ-013 SHALL run every access as one classic single cycle: cyc=stb=1 with address, data and we held until the first cycle in which ack or err is sampled high.
REQ-014 SHALL deassert cyc/stb for exactly one gap cycle after each ack; read data SHALL be captured from wb_data_i in that gap cycle, because the target registers its read data.
REQ-015 SHALL accept start only in IDLE with busy=0; start while busy SHALL be ignored.
REQ-016 SHALL, in IDLE with width_q=0 or height=0 on start, pulse done on the next cycle with no bus cycle.
REQ-017 SHALL run this state sequence: IDLE -> GETBUF -> PIX(x4) -> PTR -> CSET -> POLL -> CCLR -> NEXT -> (PIX | FSET | DONE); FSET -> FPOLL -> FCLR -> DONE -> IDLE.
REQ-018 SHALL, in GETBUF, read status once; the target buffer tb SHALL be ~status[12], latched.
REQ-019 SHALL, in PIX, write color to offsets 0x00, 0x04, 0x08 and 0x0C in order.
REQ-020 SHALL, in PTR, write pointer = {7'b0, tb, r[10:0], c[8:0], 4'b0}, with r = (row + y) mod 2048 and c = (col_q + x) mod 512.
REQ-021 SHALL, in CSET, write command = 32'h1; in POLL, read status repeatedly (one read per transaction) until bit 0 = 1; in CCLR, write command = 32'h0.
REQ-022 SHALL, in NEXT, step x first and then y, in raster order; after x = width_q-1 and y = height-1 it SHALL go to FSET if flip was latched, else to DONE.
REQ-023 SHALL, in FSET, write command = 32'h10; in FPOLL, read status until bit 12 = tb; in FCLR, write command = 32'h0.
REQ-024 SHALL, in DONE, pulse done for one cycle and return to IDLE; busy SHALL be 1 in all states except IDLE.
REQ-025 SHALL, on wb_err sampled high, end the cycle, set error, skip the remaining work and go to DONE without a command clear; error SHALL clear on the next accepted start.
REQ-026 SHALL, when ack and err are both high, treat the cycle as err.

Reset
REQ-027 SHALL, on rst_n low at any time, immediately force IDLE with wb_cyc=wb_stb=wb_we=0, wb_adr=0, wb_data_o=0, busy=0, done=0 and error=0.
REQ-028 SHALL clear all counters and latched inputs on reset.
REQ-029 SHALL NOT restore a target command register left set by a reset mid-operation; software clears it.

Configuration
REQ-030 SHALL, when macro FB_FILL_POLL_TIMEOUT_EN is defined, count polls in POLL/FPOLL; on reaching POLL_LIMIT reads without the condition met, it SHALL set error and go to DONE.
REQ-031 SHALL, when FB_FILL_POLL_TIMEOUT_EN is undefined, poll indefinitely and contain no timeout counter.

Verification
REQ-032 SHALL check: BASE_ADDR=0x100, col_q=3, row=5, width_q=1, height=1, color=0xAABBCCDD, status[12]=0 -> four writes of 0xAABBCCDD to 0x100-0x10C, pointer 0x0100_A030, 0x1 to 0x114, poll at 0x118, 0x0 to 0x114, one done pulse.
REQ-033 SHALL check: col_q=511, width_q=2 -> pointer column fields 511 then 0 (wrap), with the row unchanged.
REQ-034 SHALL check: flip=1, status[12]=1 at start, FPOLL sees status[12]=0 on the third read -> target buffer bit 24=0, 0x10 then 0x0 written to 0x114, then done.
REQ-035 SHALL check: wb_err on the second PIX write -> error=1, no further bus cycles, done pulse; the next start clears error.
REQ-036 SHALL check: rst_n low during POLL -> wb_cyc=0 and busy=0 in the same cycle; with FB_FILL_POLL_TIMEOUT_EN and POLL_LIMIT=4 and WRITE_ACK held at 0 -> error after the 4th poll read.
REQ-037 SHALL check: start with height=0 -> done on the next cycle and no wb_cyc assertion.
